// File: rtl/param_lfsr_seg.sv
// Parameterised LFSR with selectable Fibonacci / Galois update, seed
// capture, cycle-length measurement, lock-up recovery and a two-digit
// active-low seven-segment view of the low byte of the state.
module param_lfsr_seg #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] FTAPS = WIDTH'(8'h1D),
    parameter logic [WIDTH-1:0] GTAPS = WIDTH'(8'hB8)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             run,
    input  logic             step,
    input  logic             galois,
    output logic [WIDTH-1:0] random,
    output logic [WIDTH-1:0] period,
    output logic             wrap,
    output logic             lockup,
    output logic [6:0]       seg1,
    output logic [6:0]       seg2
);

    logic [WIDTH-1:0] random_q, random_d;
    logic [WIDTH-1:0] seed_q,   seed_d;
    logic [WIDTH-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             wrap_q,   wrap_d;
    logic             lockup_q, lockup_d;
    logic             step_q,   step_d;

    logic             advance;
    logic [WIDTH-1:0] fib_next;
    logic [WIDTH-1:0] gal_next;
    logic [WIDTH-1:0] raw_next;
    logic [WIDTH-1:0] adv_next;
    logic [WIDTH-1:0] load_val;
    logic [39:0]      disp_ext;

    // Active-low {g..a} pattern for one hex digit.
    function automatic logic [6:0] hex7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Next-state computation: load beats advance; an all-zero successor is
    // replaced by 1 so the register can never stick in the dead state.
    always_comb begin
        advance  = run | (step & ~step_q);
        fib_next = {^(random_q & FTAPS), random_q[WIDTH-1:1]};
        gal_next = {1'b0, random_q[WIDTH-1:1]} ^ (random_q[0] ? GTAPS : '0);
        raw_next = galois ? gal_next : fib_next;
        adv_next = (raw_next == '0) ? WIDTH'(1) : raw_next;
        load_val = (seed == '0) ? WIDTH'(1) : seed;

        random_d = random_q;
        seed_d   = seed_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        wrap_d   = 1'b0;
        lockup_d = 1'b0;
        step_d   = step;

        if (load) begin
            random_d = load_val;
            seed_d   = load_val;
            cnt_d    = '0;
        end else if (advance) begin
            random_d = adv_next;
            lockup_d = (raw_next == '0);
            if (adv_next == seed_q) begin
                wrap_d   = 1'b1;
                period_d = cnt_q + WIDTH'(1);
                cnt_d    = '0;
            end else begin
                cnt_d    = cnt_q + WIDTH'(1);
            end
        end
    end

    // State registers with asynchronous reset back to state 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            random_q <= WIDTH'(1);
            seed_q   <= WIDTH'(1);
            cnt_q    <= '0;
            period_q <= '0;
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
            step_q   <= 1'b0;
        end else begin
            random_q <= random_d;
            seed_q   <= seed_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            wrap_q   <= wrap_d;
            lockup_q <= lockup_d;
            step_q   <= step_d;
        end
    end

    // Display decode of the low byte; bits above WIDTH read as zero.
    always_comb begin
        disp_ext = 40'(random_q);
        seg1     = hex7(disp_ext[7:4]);
        seg2     = hex7(disp_ext[3:0]);
    end

    assign random = random_q;
    assign period = period_q;
    assign wrap   = wrap_q;
    assign lockup = lockup_q;

endmodule

// File: tb/tb_param_lfsr_seg.sv
// Bench for param_lfsr_seg: directed and randomized stimulus against a
// behavioural model, on a default 8-bit instance and a 4-bit instance whose
// Fibonacci taps exclude bit 0 so that lock-up recovery is reachable.
module tb_param_lfsr_seg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, load, run, step, galois;
    logic [7:0] seed;

    logic [7:0] random1, period1;
    logic       wrap1, lockup1;
    logic [6:0] seg1a, seg2a;

    logic [3:0] random2, period2;
    logic       wrap2, lockup2;
    logic [6:0] seg1b, seg2b;

    param_lfsr_seg u1 (
        .clk(clk), .rst(rst), .load(load), .seed(seed), .run(run), .step(step),
        .galois(galois), .random(random1), .period(period1), .wrap(wrap1),
        .lockup(lockup1), .seg1(seg1a), .seg2(seg2a)
    );

    param_lfsr_seg #(.WIDTH(4), .FTAPS(4'h2), .GTAPS(4'h9)) u2 (
        .clk(clk), .rst(rst), .load(load), .seed(seed[3:0]), .run(run), .step(step),
        .galois(galois), .random(random2), .period(period2), .wrap(wrap2),
        .lockup(lockup2), .seg1(seg1b), .seg2(seg2b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int unsigned m_w [2];
    int unsigned m_f [2];
    int unsigned m_g [2];
    int unsigned m_rand [2];
    int unsigned m_seed [2];
    int unsigned m_cnt [2];
    int unsigned m_per [2];
    int unsigned m_wrap [2];
    int unsigned m_lock [2];
    bit          m_stepq;

    function automatic int unsigned parity(input int unsigned v);
        int unsigned p = 0;
        for (int i = 0; i < 32; i++) p ^= (v >> i) & 1;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_rand[k] = 1; m_seed[k] = 1; m_cnt[k] = 0;
            m_per[k]  = 0; m_wrap[k] = 0; m_lock[k] = 0;
        end
        m_stepq = 0;
    endtask

    task automatic model_clock();
        bit adv;
        int unsigned mask, sd, r, n;
        if (rst) begin
            model_reset();
            return;
        end
        adv = run || (step && !m_stepq);
        for (int k = 0; k < 2; k++) begin
            mask = (1 << m_w[k]) - 1;
            sd   = seed & mask;
            if (load) begin
                m_rand[k] = (sd == 0) ? 1 : sd;
                m_seed[k] = m_rand[k];
                m_cnt[k]  = 0;
                m_wrap[k] = 0;
                m_lock[k] = 0;
            end else if (adv) begin
                r = m_rand[k];
                if (galois) n = (r >> 1) ^ ((r & 1) ? m_g[k] : 0);
                else        n = (r >> 1) | (parity(r & m_f[k]) << (m_w[k] - 1));
                n &= mask;
                m_lock[k] = (n == 0);
                if (n == 0) n = 1;
                m_cnt[k] = (m_cnt[k] + 1) & mask;
                if (n == m_seed[k]) begin
                    m_wrap[k] = 1;
                    m_per[k]  = m_cnt[k];
                    m_cnt[k]  = 0;
                end else begin
                    m_wrap[k] = 0;
                end
                m_rand[k] = n;
            end else begin
                m_wrap[k] = 0;
                m_lock[k] = 0;
            end
        end
        m_stepq = step;
    endtask

    task automatic cyc();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".rand1"}, random1, m_rand[0]);
        chk({tag, ".per1"},  period1, m_per[0]);
        chk({tag, ".wrap1"}, wrap1,   m_wrap[0]);
        chk({tag, ".lock1"}, lockup1, m_lock[0]);
        chk({tag, ".seg1a"}, seg1a,   SEG_TAB[(m_rand[0] >> 4) & 15]);
        chk({tag, ".seg2a"}, seg2a,   SEG_TAB[m_rand[0] & 15]);
        chk({tag, ".rand2"}, random2, m_rand[1]);
        chk({tag, ".per2"},  period2, m_per[1]);
        chk({tag, ".wrap2"}, wrap2,   m_wrap[1]);
        chk({tag, ".lock2"}, lockup2, m_lock[1]);
        chk({tag, ".seg1b"}, seg1b,   SEG_TAB[(m_rand[1] >> 4) & 15]);
        chk({tag, ".seg2b"}, seg2b,   SEG_TAB[m_rand[1] & 15]);
    endtask

    initial begin
        logic [7:0] fib_exp [5];
        int         wraps, locks, changes;
        logic [7:0] prev;

        m_w = '{8, 4};
        m_f = '{32'h1D, 32'h2};
        m_g = '{32'hB8, 32'h9};
        fib_exp = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h88};

        rst = 1'b1; load = 1'b0; seed = 8'h00; run = 1'b0; step = 1'b0; galois = 1'b0;
        model_reset();
        repeat (2) cyc();
        chk_all("reset");
        chk("reset_rand", random1, 32'h01);

        // Fibonacci sequence out of reset
        rst = 1'b0; run = 1'b1; galois = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("fib_seq", random1, fib_exp[i]);
            chk_all("fib");
            if (i == 0) begin
                chk("seg1_at_80", seg1a, 32'h00);
                chk("seg2_at_80", seg2a, 32'h40);
            end
        end

        // Galois sequence, then mode switch
        rst = 1'b1; #1; model_reset();
        chk("async_rst_rand", random1, 32'h01);
        rst = 1'b0; galois = 1'b1;
        cyc(); chk("gal_b8", random1, 32'hB8);
        cyc(); chk("gal_5c", random1, 32'h5C);
        galois = 1'b0;
        cyc(); chk("switch_ae", random1, 32'hAE);
        chk_all("gal");

        // Full cycle from seed 1
        load = 1'b1; seed = 8'h01; run = 1'b1; galois = 1'b0;
        cyc();
        load = 1'b0;
        wraps = 0; locks = 0;
        for (int i = 1; i <= 255; i++) begin
            cyc();
            chk_all("cycle");
            if (wrap1) wraps++;
            if (lockup1) locks++;
            if (i == 1) chk("lock2_pulse", lockup2, 32'h1);
            if (i == 255) chk("wrap_at_255", wrap1, 32'h1);
        end
        chk("wrap_count", wraps, 32'd1);
        chk("period_255", period1, 32'd255);
        chk("lock_count", locks, 32'd0);

        // Step mode: step held high ten cycles -> one advance
        run = 1'b0; step = 1'b0;
        cyc();
        prev = random1; changes = 0;
        step = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk_all("step");
            if (random1 != prev) changes++;
            prev = random1;
        end
        step = 1'b0;
        cyc(); cyc();
        chk("step_once", changes, 32'd1);
        chk_all("step_idle");

        // Load and step edge together: load wins, no later advance
        load = 1'b1; step = 1'b1; seed = 8'h3C;
        cyc();
        chk("load_step", random1, 32'h3C);
        load = 1'b0;
        cyc();
        chk("load_step_hold", random1, 32'h3C);
        step = 1'b0;

        // Zero seed is replaced by 1
        load = 1'b1; seed = 8'h00;
        cyc();
        chk("seed_zero", random1, 32'h01);
        chk_all("seed_zero");
        load = 1'b0;

        // Randomized mix of run/step/galois/load
        for (int i = 0; i < 300; i++) begin
            run    = ($urandom_range(0, 3) == 0);
            step   = $urandom_range(0, 1);
            galois = $urandom_range(0, 1);
            load   = ($urandom_range(0, 15) == 0);
            seed   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            cyc();
            chk_all("rand");
        end

        // Reset in the middle of a 100-advance count
        load = 1'b1; seed = 8'h5A; run = 1'b1; galois = 1'b0; step = 1'b0;
        cyc();
        load = 1'b0;
        repeat (100) cyc();
        chk_all("pre_rst");
        #2; rst = 1'b1; #1; model_reset();
        chk("midrst_rand", random1, 32'h01);
        chk("midrst_period", period1, 32'h00);
        chk_all("midrst");
        rst = 1'b0;
        cyc();
        chk("after_rst", random1, 32'h80);
        chk_all("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
